// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter with an internal bit-rate divider.
// Define UART_PARITY_EN to add an even-parity bit, which makes the frame 8E1.
module uart_tx_core #(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200,
   parameter int CLK_DIV  = CLK_FREQ / BAUD
) (
   input  logic       sys_clk_i,
   input  logic       sys_rst_i,
   input  logic       uart_wr_i,
   input  logic [7:0] uart_dat_i,
   output logic       uart_busy,
   output logic       uart_tx
);
   localparam int CW = $clog2(CLK_DIV);
`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d, busy_q, busy_d;
   logic          bit_end;
`ifdef UART_PARITY_EN
   logic          par_q, par_d;
`endif
   assign bit_end   = cnt_q == CW'(CLK_DIV - 1);
   assign uart_tx   = tx_q;
   assign uart_busy = busy_q;
   // state, divider, shifter and the registered line/busy outputs
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
`ifdef UART_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
`ifdef UART_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end
   // next-state logic; tx_d is the value the line takes on the coming edge
   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
      idx_d   = idx_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
`ifdef UART_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (uart_wr_i && !busy_q) begin
               state_d = START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
               shift_d = uart_dat_i;
`ifdef UART_PARITY_EN
               par_d   = ^uart_dat_i;
`endif
            end
         end
         START: if (bit_end) begin
            state_d = DATA;
            idx_d   = '0;
            tx_d    = shift_q[0];
         end
         DATA: if (bit_end) begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
            if (idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
               state_d = PARITY;
               tx_d    = par_q;
`else
               state_d = STOP;
               tx_d    = 1'b1;
`endif
            end else
               tx_d = shift_q[1];
         end
`ifdef UART_PARITY_EN
         PARITY: if (bit_end) begin
            state_d = STOP;
            tx_d    = 1'b1;
         end
`endif
         STOP: if (bit_end) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed self-checking bench for uart_tx_core (also covers UART_PARITY_EN builds).
module tb_uart_tx_core;
   localparam int DIV = 434;
`ifdef UART_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * DIV;
   logic       sys_clk_i = 1'b0, sys_rst_i = 1'b1, uart_wr_i = 1'b0;
   logic [7:0] uart_dat_i = 8'h00;
   logic       uart_busy, uart_tx;
   int         tests = 0, fails = 0;
   logic       tx_log [0:20000];
   logic       busy_log [0:20000];

   uart_tx_core #(.CLK_FREQ(50000000), .BAUD(115200)) dut (
      .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i), .uart_wr_i(uart_wr_i),
      .uart_dat_i(uart_dat_i), .uart_busy(uart_busy), .uart_tx(uart_tx)
   );

   always #10 sys_clk_i = ~sys_clk_i;

   function automatic logic [NB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
      return {1'b1, ^d, d, 1'b0};
`else
      return {1'b1, d, 1'b0};
`endif
   endfunction

   function automatic int count_low(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (tx_log[i] === 1'b0) n++;
      return n;
   endfunction

   function automatic int count_busy(input int lo, input int hi);
      int n = 0;
      for (int i = lo; i < hi; i++) if (busy_log[i] === 1'b1) n++;
      return n;
   endfunction

   function automatic int bit_errs(input int base, input logic [NB-1:0] f);
      int n = 0;
      for (int b = 0; b < NB; b++) if (tx_log[base + b*DIV + DIV/2] !== f[b]) n++;
      return n;
   endfunction

   task automatic start_write(input logic [7:0] d);
      @(negedge sys_clk_i);
      uart_wr_i  = 1'b1;
      uart_dat_i = d;
   endtask

   // index i holds the outputs just after accept edge + i
   task automatic capture(input int n, input int clr_at, input int w2_at, input logic [7:0] d2, input int w2_len);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk_i);
         tx_log[i]   = uart_tx;
         busy_log[i] = uart_busy;
         if (i == clr_at) begin
            uart_wr_i  = 1'b0;
            uart_dat_i = 8'h00;
         end
         if (i == w2_at) begin
            uart_wr_i  = 1'b1;
            uart_dat_i = d2;
         end
         if (w2_at >= 0 && i == w2_at + w2_len) uart_wr_i = 1'b0;
      end
   endtask

   task automatic test_reset;
      sys_rst_i = 1'b1;
      repeat (2) @(negedge sys_clk_i);
      tests++; if (uart_tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", uart_tx); end
      tests++; if (uart_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", uart_busy); end
      sys_rst_i = 1'b0;
      @(negedge sys_clk_i);
      sys_rst_i = 1'b1;
      repeat (10) @(negedge sys_clk_i);
      tests++; if ({uart_tx, uart_busy} !== 2'b10) begin fails++; $display("FAIL idle_reset got tx/busy %b want 10", {uart_tx, uart_busy}); end
      sys_rst_i = 1'b0;
      repeat (2) @(negedge sys_clk_i);
   endtask

   task automatic test_single;
      int r;
      start_write(8'hFE);
      capture(FL + 600, 1, -1, 8'h00, 0);
      tests++; if ({tx_log[0], busy_log[0]} !== 2'b01) begin fails++; $display("FAIL single_first_edge got tx/busy %b want 01", {tx_log[0], busy_log[0]}); end
      r = 0;
      while (r < FL && tx_log[r] === 1'b0) r++;
      tests++; if (r != 868) begin fails++; $display("FAIL single_low_run got %0d want 868", r); end
      tests++; if (count_low(0, FL + 600) != 868) begin fails++; $display("FAIL single_total_low got %0d want 868", count_low(0, FL + 600)); end
      tests++; if (count_busy(0, FL + 600) != FL) begin fails++; $display("FAIL single_busy_len got %0d want %0d", count_busy(0, FL + 600), FL); end
      tests++; if ({busy_log[FL-1], busy_log[FL]} !== 2'b10) begin fails++; $display("FAIL single_busy_fall got %b want 10", {busy_log[FL-1], busy_log[FL]}); end
      tests++; if (bit_errs(0, frame_of(8'hFE)) != 0) begin fails++; $display("FAIL single_bits got %0d bad bits want 0", bit_errs(0, frame_of(8'hFE))); end
   endtask

   task automatic test_busy_reject;
      start_write(8'hA3);
      capture(FL + 2000, 0, 1500, 8'h55, 3);
      tests++; if (bit_errs(0, frame_of(8'hA3)) != 0) begin fails++; $display("FAIL reject_bits got %0d bad bits want 0", bit_errs(0, frame_of(8'hA3))); end
      tests++; if (count_busy(0, FL + 2000) != FL) begin fails++; $display("FAIL reject_busy_len got %0d want %0d", count_busy(0, FL + 2000), FL); end
      tests++; if (count_low(FL, FL + 2000) != 0) begin fails++; $display("FAIL reject_no_second got %0d low want 0", count_low(FL, FL + 2000)); end
   endtask

   task automatic test_back_to_back;
      int low_exp;
`ifdef UART_PARITY_EN
      low_exp = 10 * DIV;
`else
      low_exp = 9 * DIV;
`endif
      start_write(8'h00);
      capture(2*FL + 300, 0, FL - 1, 8'hA5, 2);
      tests++; if ({busy_log[FL], tx_log[FL]} !== 2'b01) begin fails++; $display("FAIL b2b_fall_edge got busy/tx %b want 01", {busy_log[FL], tx_log[FL]}); end
      tests++; if ({busy_log[FL+1], tx_log[FL+1]} !== 2'b10) begin fails++; $display("FAIL b2b_accept got busy/tx %b want 10", {busy_log[FL+1], tx_log[FL+1]}); end
      tests++; if (count_low(0, FL) != low_exp) begin fails++; $display("FAIL b2b_first_low got %0d want %0d", count_low(0, FL), low_exp); end
      tests++; if (bit_errs(FL + 1, frame_of(8'hA5)) != 0) begin fails++; $display("FAIL b2b_bits got %0d bad bits want 0", bit_errs(FL + 1, frame_of(8'hA5))); end
      tests++; if ({busy_log[2*FL], busy_log[2*FL+1]} !== 2'b10) begin fails++; $display("FAIL b2b_second_len got %b want 10", {busy_log[2*FL], busy_log[2*FL+1]}); end
   endtask

   task automatic test_reset_mid;
      start_write(8'h52);
      capture(4*DIV + 200, 0, -1, 8'h00, 0);
      tests++; if ({uart_tx, uart_busy} !== 2'b01) begin fails++; $display("FAIL mid_before got tx/busy %b want 01", {uart_tx, uart_busy}); end
      #3 sys_rst_i = 1'b1;
      #1;
      tests++; if ({uart_tx, uart_busy} !== 2'b10) begin fails++; $display("FAIL mid_async got tx/busy %b want 10", {uart_tx, uart_busy}); end
      @(negedge sys_clk_i);
      sys_rst_i = 1'b0;
      @(negedge sys_clk_i);
      start_write(8'hC3);
      capture(FL + 200, 0, -1, 8'h00, 0);
      tests++; if (bit_errs(0, frame_of(8'hC3)) != 0) begin fails++; $display("FAIL mid_resume_bits got %0d bad bits want 0", bit_errs(0, frame_of(8'hC3))); end
      tests++; if (count_busy(0, FL + 200) != FL) begin fails++; $display("FAIL mid_resume_busy got %0d want %0d", count_busy(0, FL + 200), FL); end
   endtask

`ifdef UART_PARITY_EN
   task automatic test_parity;
      start_write(8'h07);
      capture(FL + 50, 0, -1, 8'h00, 0);
      tests++; if (tx_log[9*DIV + DIV/2] !== 1'b1) begin fails++; $display("FAIL parity_07 got %b want 1", tx_log[9*DIV + DIV/2]); end
      tests++; if (count_busy(0, FL + 50) != 4774) begin fails++; $display("FAIL parity_busy got %0d want 4774", count_busy(0, FL + 50)); end
      start_write(8'h03);
      capture(FL + 50, 0, -1, 8'h00, 0);
      tests++; if (tx_log[9*DIV + DIV/2] !== 1'b0) begin fails++; $display("FAIL parity_03 got %b want 0", tx_log[9*DIV + DIV/2]); end
   endtask
`endif

   initial begin
      test_reset;
      test_single;
      test_busy_reject;
      test_back_to_back;
      test_reset_mid;
`ifdef UART_PARITY_EN
      test_parity;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_core.md
Name:
uart_tx_core

Overview:
- Byte-oriented UART transmitter: accepts one 8-bit word per write strobe and serialises it on a single TX line.
- Frame format: 8N1 by default (1 start bit, 8 data bits LSB first, 1 stop bit).
- Sits between a system-bus write port and the board TX pin; `uart_busy` throttles the writer.
- Runs from the 50 MHz system clock; bit timing comes from an internal clock-enable divider.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD, 115200: line rate in bit/s.
- CLK_DIV, CLK_FREQ/BAUD (434, integer truncation): system clocks per bit. Legal range ≥ 2. Overridable directly.

Ports:
- sys_clk_i  input  1  system clock; all logic on its rising edge.
- sys_rst_i  input  1  reset, asynchronous, active-high.
- uart_wr_i  input  1  write strobe, sampled on rising edge.
- uart_dat_i  input  8  byte to transmit; valid with uart_wr_i.
- uart_busy  output  1  high while a frame is in progress; registered.
- uart_tx  output  1  serial line, idle high; registered (glitch-free).

Behaviour:
- Interface: one clock, sys_clk_i. Reset sys_rst_i is asynchronous and active-high.
- Reset values:
  - uart_tx=1, uart_busy=0, state=IDLE.
  - Bit counter, divider counter and shift register cleared.
- Reset asserted mid-frame aborts the frame immediately. The line returns high asynchronously; the partial frame is not resumed.
- Write acceptance:
  - A write is accepted on a rising edge where uart_wr_i=1 and the registered uart_busy=0.
  - uart_dat_i is latched into the shift register on that edge.
  - Writes while busy=1 are ignored, not queued. A strobe held for several cycles therefore sends exactly one frame.
- Latency: on the accepting edge, state=START, uart_tx=0 and uart_busy=1 all take effect; the start bit begins that edge.
- Divider:
  - Counts 0..CLK_DIV-1, restarting at 0 on acceptance.
  - A bit period ends when the count reaches CLK_DIV-1; each bit lasts exactly CLK_DIV clocks.
- State machine:
  - IDLE: tx=1. On accepted write → START.
  - START: tx=0 for CLK_DIV clocks → DATA, bit index 0.
  - DATA: tx=shift[0]; at each bit end, shift right and index+1. After index 7 → STOP (or PARITY, see Optional Feature).
  - STOP: tx=1 for CLK_DIV clocks → IDLE, busy cleared on that same edge.
- Frame length: 10*CLK_DIV clocks from the accepting edge to the busy-falling edge.
- Back-to-back: a write sampled on the edge where busy falls is ignored, because the sampled busy was 1. The earliest next acceptance is the following edge.
- uart_dat_i may change freely after acceptance; the latched copy is used.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV clocks.
  - Frame becomes 11*CLK_DIV clocks; busy timing extends accordingly.
- Undefined: no PARITY state and no parity logic; 8N1 only.

Test Plan:
- Reset: hold sys_rst_i=1 for 2 clocks → uart_tx=1, uart_busy=0. Assert reset for 10 clocks while idle → outputs unchanged.
- Single frame: CLK_DIV=434, write 0xFE (0b11111110) with uart_wr_i held 2 clocks → exactly one frame.
  - Sequence: tx low 868 clocks (start + bit0=0), then high 7*434 clocks (bits 1..7), then stop high 434.
  - uart_busy high exactly 4340 clocks.
- Busy rejection: pulse a second write of 0x55 mid-frame → first frame's bits unaffected; no second frame follows.
- Back-to-back: write 0x00, then write 0xA5 on the first edge after busy falls → frames contiguous.
  - 0xA5 appears LSB first: 1,0,1,0,0,1,0,1.
  - Total line low time in the 0x00 frame is 9*434 clocks.
- Reset mid-frame: assert sys_rst_i during data bit 3 → uart_tx=1 and uart_busy=0 immediately, without waiting for a clock edge. A new write after release sends a complete, correct frame.
- Parity (UART_PARITY_EN): write 0x07 → parity bit 1; write 0x03 → parity bit 0. uart_busy high 11*434 clocks.
